// File: rtl/wb_regfile_if.sv
// ============================================================================
// Module   : wb_regfile_if
// Brief    : MEM/WB writeback bus between pipeline register and register file.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              imem_to_reg;
    logic              ipc_to_reg;
    logic              ireg_write;
    logic [DATA_W-1:0] iPC;
    logic [DATA_W-1:0] iInstruction;
    logic [DATA_W-1:0] ialu_res;
    logic [DATA_W-1:0] iData_mem_res;
    logic [ADDR_W-1:0] iwrite_addr;
    logic [ADDR_W-1:0] read_addr1;
    logic [ADDR_W-1:0] read_addr2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] wb_data;
    logic              wb_valid;
    logic [31:0]       retired_count;

    modport master (
        output imem_to_reg, ipc_to_reg, ireg_write, iPC, iInstruction,
               ialu_res, iData_mem_res, iwrite_addr, read_addr1, read_addr2,
        input  read_data1, read_data2, wb_data, wb_valid, retired_count
    );

    modport slave (
        input  imem_to_reg, ipc_to_reg, ireg_write, iPC, iInstruction,
               ialu_res, iData_mem_res, iwrite_addr, read_addr1, read_addr2,
        output read_data1, read_data2, wb_data, wb_valid, retired_count
    );
endinterface

`default_nettype wire

// File: rtl/wb_regfile.sv
// ============================================================================
// Module   : wb_regfile
// Brief    : Writeback stage: result select, 2**ADDR_W x DATA_W register file,
//            two read ports and retired-instruction counter.
//            Optional macro WB_BYPASS_EN: write-before-read on the read ports.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_regfile #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int LINK_OFFSET = 4
) (
    input  wire logic     clock,
    input  wire logic     reset,
    wb_regfile_if.slave   bus
);
    localparam int                NREG     = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] C_LINK   = DATA_W'(LINK_OFFSET);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [31:0]       retired_count_q;
    logic [31:0]       retired_count_d;

    logic [DATA_W-1:0] wb_data;
    logic              wb_valid;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;

    // Link value has priority over load data.
    always_comb begin
        wb_data = bus.ialu_res;
        if (bus.ipc_to_reg) begin
            wb_data = bus.iPC + C_LINK;
        end else if (bus.imem_to_reg) begin
            wb_data = bus.iData_mem_res;
        end
    end

    assign wb_valid = bus.ireg_write && (bus.iwrite_addr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wb_valid) begin
            regs_d[bus.iwrite_addr] = wb_data;
        end
    end

    always_comb begin
        retired_count_d = retired_count_q;
        if (bus.iInstruction != '0) begin
            retired_count_d = retired_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            retired_count_q <= '0;
        end else begin
            regs_q          <= regs_d;
            retired_count_q <= retired_count_d;
        end
    end

    // Address 0 reads as zero; wb_valid already excludes address 0 for bypass.
    always_comb begin
        read_data1 = (bus.read_addr1 == '0) ? '0 : regs_q[bus.read_addr1];
        read_data2 = (bus.read_addr2 == '0) ? '0 : regs_q[bus.read_addr2];
`ifdef WB_BYPASS_EN
        if (wb_valid && (bus.read_addr1 == bus.iwrite_addr)) begin
            read_data1 = wb_data;
        end
        if (wb_valid && (bus.read_addr2 == bus.iwrite_addr)) begin
            read_data2 = wb_data;
        end
`endif
    end

    assign bus.read_data1    = read_data1;
    assign bus.read_data2    = read_data2;
    assign bus.wb_data       = wb_data;
    assign bus.wb_valid      = wb_valid;
    assign bus.retired_count = retired_count_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// Module   : tb_wb_regfile
// Brief    : Self-checking bench for wb_regfile with an expected-value queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_regfile;
    logic clock;
    logic reset;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .LINK_OFFSET(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];

    logic [31:0] mreg [32];
    logic [31:0] mcount;

    logic        s_wr, s_mtr, s_ptr;
    logic [4:0]  s_addr;
    logic [31:0] s_alu, s_mem, s_pc, s_instr;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            check_value({tag, "_noexp"}, 32'd0, 32'd1);
        end else begin
            check_value(tag, obs, exp_q.pop_front());
        end
    endtask

    function automatic logic [31:0] model_wb();
        if (s_ptr)      return s_pc + 32'd4;
        else if (s_mtr) return s_mem;
        else            return s_alu;
    endfunction

    function automatic logic model_valid();
        return s_wr && (s_addr != 5'd0);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (model_valid() && a == s_addr) return model_wb();
`endif
        return mreg[a];
    endfunction

    task automatic apply(input logic wr, input logic [4:0] addr, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc, input logic mtr,
                         input logic ptr, input logic [31:0] instr);
        s_wr = wr; s_addr = addr; s_alu = alu; s_mem = mem; s_pc = pc;
        s_mtr = mtr; s_ptr = ptr; s_instr = instr;
        bus.ireg_write    = wr;
        bus.iwrite_addr   = addr;
        bus.ialu_res      = alu;
        bus.iData_mem_res = mem;
        bus.iPC           = pc;
        bus.imem_to_reg   = mtr;
        bus.ipc_to_reg    = ptr;
        bus.iInstruction  = instr;
    endtask

    task automatic idle();
        apply(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        mcount = 32'd0;
    endtask

    task automatic step();
        @(posedge clock);
        if (!reset) begin
            if (model_valid()) mreg[s_addr] = model_wb();
            if (s_instr != 32'd0) mcount = mcount + 32'd1;
        end
        #1;
    endtask

    task automatic read_check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        bus.read_addr1 = a1;
        bus.read_addr2 = a2;
        #1;
        sb_push(model_read(a1)); sb_check({tag, "_rd1"}, bus.read_data1);
        sb_push(model_read(a2)); sb_check({tag, "_rd2"}, bus.read_data2);
    endtask

    logic [31:0] byp_exp;

    initial begin
        model_reset();
        idle();
        bus.read_addr1 = 5'd0;
        bus.read_addr2 = 5'd0;
        reset = 1'b1;
        #2;
        sb_push(32'd0); sb_check("rst_count", bus.retired_count);
        read_check("rst_regs", 5'd5, 5'd31);
        @(negedge clock);
        reset = 1'b0;
        step();

        // Retire counter: bubbles do not count
        apply(1'b0, 5'd0, 0, 0, 0, 0, 0, 32'h8C020004); step();
        apply(1'b0, 5'd0, 0, 0, 0, 0, 0, 32'h00000000); step();
        apply(1'b0, 5'd0, 0, 0, 0, 0, 0, 32'hAC020008); step();
        sb_push(32'd2); sb_check("retire_2", bus.retired_count);
        check_value("retire_model", bus.retired_count, mcount);

        // ALU writeback
        apply(1'b1, 5'd8, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0, 32'h00000013);
        #1;
        sb_push(32'hDEADBEEF); sb_check("alu_wb_data", bus.wb_data);
        sb_push(32'd1);        sb_check("alu_wb_valid", 32'(bus.wb_valid));
        step();
        read_check("alu_rd", 5'd8, 5'd8);

        // Load, then link with both selects set
        apply(1'b1, 5'd9, 32'h0BAD0BAD, 32'h55AA55AA, 32'h0, 1, 0, 32'h8C090000);
        #1;
        sb_push(32'h55AA55AA); sb_check("load_wb_data", bus.wb_data);
        step();
        apply(1'b1, 5'd31, 32'h0BAD0BAD, 32'h55AA55AA, 32'h00400010, 1, 1, 32'h0C000000);
        #1;
        sb_push(32'h00400014); sb_check("link_wb_data", bus.wb_data);
        step();
        read_check("load_link_rd", 5'd9, 5'd31);
        sb_push(32'h00400014); sb_check("link_reg31", bus.read_data2);

        // Register zero is never written
        apply(1'b1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h00000013);
        #1;
        sb_push(32'd0); sb_check("r0_wb_valid", 32'(bus.wb_valid));
        step();
        read_check("r0_rd", 5'd0, 5'd0);

        // Same-cycle read and write of reg3
        apply(1'b1, 5'd3, 32'h11, 0, 0, 0, 0, 32'h00000013); step();
        apply(1'b1, 5'd3, 32'h22, 0, 0, 0, 0, 32'h00000013);
`ifdef WB_BYPASS_EN
        byp_exp = 32'h22;
`else
        byp_exp = 32'h11;
`endif
        bus.read_addr1 = 5'd3;
        bus.read_addr2 = 5'd3;
        #1;
        sb_push(byp_exp); sb_check("bypass_rd2", bus.read_data2);
        sb_push(byp_exp); sb_check("bypass_rd1", bus.read_data1);
        step();
        idle();
        #1;
        sb_push(32'h22); sb_check("bypass_after", bus.read_data2);

        // Unknown load data is ignored when not selected
        apply(1'b1, 5'd10, 32'hCAFEF00D, 32'hXXXXXXXX, 0, 0, 0, 32'h00000013); step();
        idle();
        read_check("xmem_rd", 5'd10, 5'd3);

        // Random writes, each read back on one port while writing
        for (int i = 0; i < 24; i++) begin
            apply($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom, $urandom,
                  $urandom & 32'hFFFFFFFC, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom | 32'd1);
            #1;
            sb_push(model_wb()); sb_check("rand_wb_data", bus.wb_data);
            sb_push(32'(model_valid())); sb_check("rand_wb_valid", 32'(bus.wb_valid));
            read_check("rand_pre", 5'($urandom_range(0, 31)), s_addr);
            step();
        end
        idle();
        for (int a = 0; a < 32; a += 2) begin
            read_check("readback", 5'(a), 5'(a + 1));
        end
        sb_push(mcount); sb_check("rand_count", bus.retired_count);

        // Counter wrap
        @(negedge clock);
        force dut.retired_count_q = 32'hFFFFFFFE;
        #1;
        release dut.retired_count_q;
        mcount = 32'hFFFFFFFE;
        #1;
        sb_push(mcount); sb_check("wrap_preload", bus.retired_count);
        apply(1'b0, 5'd0, 0, 0, 0, 0, 0, 32'h00000013); step();
        sb_push(32'hFFFFFFFF); sb_check("wrap_max", bus.retired_count);
        step();
        sb_push(32'h00000000); sb_check("wrap_zero", bus.retired_count);

        // Reset asserted mid-cycle clears state without an edge
        apply(1'b1, 5'd5, 32'h1234, 0, 0, 0, 0, 32'h00000013); step();
        idle();
        read_check("pre_rst", 5'd5, 5'd8);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        read_check("async_rst", 5'd5, 5'd8);
        sb_push(32'd0); sb_check("async_rst_count", bus.retired_count);

        // Write pending on an edge while in reset is discarded
        apply(1'b1, 5'd6, 32'h6666, 0, 0, 0, 0, 32'h00000013); step();
        read_check("rst_write", 5'd6, 5'd6);
        sb_push(32'd0); sb_check("rst_write_count", bus.retired_count);
        @(negedge clock);
        reset = 1'b0;
        apply(1'b1, 5'd6, 32'h6666, 0, 0, 0, 0, 32'h00000013); step();
        read_check("post_rst_write", 5'd6, 5'd0);
        sb_push(32'd1); sb_check("post_rst_count", bus.retired_count);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: takes the registered MEM/WB outputs and performs writeback.
- Selects the writeback value (ALU result, load data or link address) and writes it into a 32x32 general-purpose register file.
- Serves the two decode-stage read ports and exposes the writeback value for the forwarding unit.
- Keeps a retired-instruction counter for debug.

Parameters:
DATA_W, 32, datapath and register width
ADDR_W, 5, register address width (2**ADDR_W registers)
LINK_OFFSET, 4, added to PC for jal/jalr link value

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_to_reg  input  1  select load data for writeback
ipc_to_reg  input  1  select PC+LINK_OFFSET for writeback; priority over imem_to_reg
ireg_write  input  1  writeback enable
iPC  input  DATA_W  PC of instruction in WB
iInstruction  input  DATA_W  instruction word in WB; 0 = bubble/nop
ialu_res  input  DATA_W  ALU result
iData_mem_res  input  DATA_W  data-memory read result
iwrite_addr  input  ADDR_W  destination register
read_addr1  input  ADDR_W  decode read port 1 address
read_addr2  input  ADDR_W  decode read port 2 address
read_data1  output  DATA_W  read port 1 data
read_data2  output  DATA_W  read port 2 data
wb_data  output  DATA_W  selected writeback value, to forwarding unit
wb_valid  output  1  ireg_write && iwrite_addr != 0
retired_count  output  32  count of non-bubble instructions retired

Behaviour:
- Clock and reset: single clock `clock`. Reset `reset` is asynchronous, active-high.
- Reset: all 2**ADDR_W registers <= 0 and retired_count <= 0, immediately on assertion, independent of clock. Outputs are usable on the first rising edge after deassertion.
- wb_data (combinational):
  - ipc_to_reg=1: iPC + LINK_OFFSET, modulo 2**DATA_W.
  - else imem_to_reg=1: iData_mem_res.
  - else: ialu_res.
- wb_valid (combinational): ireg_write && (iwrite_addr != 0).
- Register write: on rising edge with wb_valid=1 and reset low, reg[iwrite_addr] <= wb_data. Writes to register 0 are silently dropped; reg0 always holds 0.
- Read ports: combinational, zero-latency.
  - read_addrN=0 returns 0 regardless of any write.
  - Both ports may address the same register; both return the same value.
- Same-cycle read/write of the same register: governed by WB_BYPASS_EN (see Optional Feature).
- retired_count:
  - On each rising edge with reset low and iInstruction != 0, increments by 1.
  - Counts regardless of ireg_write (stores and branches retire too).
  - Wraps 0xFFFFFFFF -> 0.
- Reset mid-operation: a write pending on the same edge that reset asserts is discarded. Reset wins over write and increment.
- X on iData_mem_res while imem_to_reg=0 has no effect on stored state.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: read port N returns wb_data in the same cycle when wb_valid=1 and read_addrN == iwrite_addr (nonzero). This gives write-before-read semantics so decode sees the value retiring this cycle.
- Not defined: read ports return the stored register contents only. The value written on edge k is visible after edge k. The hazard unit must stall or forward for the WB->ID distance.

Test Plan:
- Reset: assert reset asynchronously mid-cycle after writing reg5=0x1234 -> read_data1 for reg5=0 and retired_count=0 immediately, without a clock edge.
- ALU writeback: ireg_write=1, iwrite_addr=8, ialu_res=0xDEADBEEF, selects 0, one edge -> read_addr1=8 gives 0xDEADBEEF; wb_data=0xDEADBEEF before the edge.
- Load and link priority:
  - imem_to_reg=1, iData_mem_res=0x55AA55AA -> reg9=0x55AA55AA.
  - Then ipc_to_reg=1 and imem_to_reg=1, iPC=0x00400010, iwrite_addr=31 -> reg31=0x00400014.
- Register zero: ireg_write=1, iwrite_addr=0, ialu_res=0xFFFFFFFF -> wb_valid=0, read of reg0=0.
- Bypass: reg3 holds 0x11; same cycle write reg3=0x22 with read_addr2=3 -> read_data2=0x22 with WB_BYPASS_EN, 0x11 without; after the edge, 0x22 in both builds.
- Retire counter:
  - Three edges with iInstruction=0x8C020004, 0x00000000, 0xAC020008 -> retired_count=2.
  - Preload-by-counting to 0xFFFFFFFF, then one non-bubble edge -> 0.
